// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-to-read bypass
// and a per-register pending-write scoreboard.
module regfile_mp #(
  parameter int XLEN = 16,
  parameter int NREG = 8,
  parameter int NRD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [AW-1:0] wr_addr_in,
  input  logic [XLEN-1:0] wr_data_in,
  input  logic issue_en,
  input  logic [AW-1:0] issue_addr_in,
  input  logic flush,
  input  logic [NRD*AW-1:0] rd_addr_in,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0] rd_busy_o,
  output logic [AW:0] busy_cnt_o
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0] cnt_nxt;
  logic wr_ok;
  logic issue_ok;

  assign wr_ok = wr_en &&
    !(ZERO_REG == 1 && wr_addr_in == '0);
  assign issue_ok = issue_en &&
    !(ZERO_REG == 1 && issue_addr_in == '0);

  // A new issue supersedes a same-cycle writeback clear.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_ok) busy_nxt[wr_addr_in] = 1'b0;
      if (issue_ok) busy_nxt[issue_addr_in] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
      busy_cnt_o <= '0;
    end else begin
      if (wr_ok) regs[wr_addr_in] <= wr_data_in;
      busy <= busy_nxt;
      busy_cnt_o <= cnt_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [XLEN-1:0] d;
    logic b;

    assign a = rd_addr_in[i*AW +: AW];

    always_comb begin
      d = regs[a];
      b = busy[a];
      if (BYPASS == 1 && wr_ok &&
          wr_addr_in == a) begin
        d = wr_data_in;
        b = 1'b0;
      end
      if (ZERO_REG == 1 && a == '0) begin
        d = '0;
        b = 1'b0;
      end
      // Bypassed write data must not leak out during reset.
      if (rst) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data_o[i*XLEN +: XLEN] = d;
    assign rd_busy_o[i] = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and
// one non-bypassing instance driven by the same stimulus.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  logic wr_en;
  logic [2:0] wr_addr_in;
  logic [15:0] wr_data_in;
  logic issue_en;
  logic [2:0] issue_addr_in;
  logic flush;
  logic [5:0] rd_addr_in;
  logic [31:0] rd_data_o;
  logic [1:0] rd_busy_o;
  logic [3:0] busy_cnt_o;
  logic [31:0] nb_data;
  logic [1:0] nb_busy;
  logic [3:0] nb_cnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in),
    .issue_en(issue_en),
    .issue_addr_in(issue_addr_in),
    .flush(flush), .rd_addr_in(rd_addr_in),
    .rd_data_o(rd_data_o),
    .rd_busy_o(rd_busy_o),
    .busy_cnt_o(busy_cnt_o)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in),
    .issue_en(issue_en),
    .issue_addr_in(issue_addr_in),
    .flush(flush), .rd_addr_in(rd_addr_in),
    .rd_data_o(nb_data),
    .rd_busy_o(nb_busy),
    .busy_cnt_o(nb_cnt)
  );

  task automatic idle();
    wr_en = 1'b0;
    issue_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    wr_addr_in = '0;
    wr_data_in = '0;
    issue_addr_in = '0;
    rd_addr_in = '0;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      rd_addr_in = {a[2:0], a[2:0]};
      #1;
      n_checks++;
      if (rd_data_o !== 32'h0 ||
          nb_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_data a=%0d: got %h/%h want 0",
                 a, rd_data_o, nb_data);
      end
      n_checks++;
      if (rd_busy_o !== 2'b00 ||
          nb_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_busy a=%0d: got %b/%b want 00",
                 a, rd_busy_o, nb_busy);
      end
    end
    n_checks++;
    if (busy_cnt_o !== 4'd0 || nb_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d want 0",
               busy_cnt_o, nb_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr_in = 3'd3;
    wr_data_in = 16'hBEEF;
    rd_addr_in = {3'd0, 3'd3};
    #1;
    n_checks++;
    if (rd_data_o[15:0] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL bypass_same: got %h want beef",
               rd_data_o[15:0]);
    end
    n_checks++;
    if (nb_data[15:0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL nobypass_same: got %h want 0000",
               nb_data[15:0]);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (rd_data_o[15:0] !== 16'hBEEF ||
        nb_data[15:0] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL write_next: got %h/%h want beef",
               rd_data_o[15:0], nb_data[15:0]);
    end
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr_in = 3'd0;
    wr_data_in = 16'h1234;
    rd_addr_in = {3'd3, 3'd0};
    #1;
    n_checks++;
    if (rd_data_o !== 32'hBEEF_0000) begin
      n_fail++;
      $display("FAIL zero_same: got %h want beef0000",
               rd_data_o);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (rd_data_o[15:0] !== 16'h0 ||
        nb_data[15:0] !== 16'h0) begin
      n_fail++;
      $display("FAIL zero_next: got %h/%h want 0000",
               rd_data_o[15:0], nb_data[15:0]);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    issue_en = 1'b1;
    issue_addr_in = 3'd5;
    rd_addr_in = {3'd5, 3'd5};
    #1;
    n_checks++;
    if (rd_busy_o !== 2'b00) begin
      n_fail++;
      $display("FAIL issue_same: got %b want 00",
               rd_busy_o);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (rd_busy_o !== 2'b11 || nb_busy !== 2'b11) begin
      n_fail++;
      $display("FAIL issue_next: got %b/%b want 11",
               rd_busy_o, nb_busy);
    end
    n_checks++;
    if (busy_cnt_o !== 4'd1) begin
      n_fail++;
      $display("FAIL issue_cnt: got %0d want 1",
               busy_cnt_o);
    end
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr_in = 3'd5;
    wr_data_in = 16'h00AA;
    #1;
    n_checks++;
    if (rd_busy_o !== 2'b00 ||
        rd_data_o !== 32'h00AA_00AA) begin
      n_fail++;
      $display("FAIL wb_bypass: got %b %h want 00 00aa00aa",
               rd_busy_o, rd_data_o);
    end
    n_checks++;
    if (nb_busy !== 2'b11 || nb_data !== 32'h0) begin
      n_fail++;
      $display("FAIL wb_nobypass: got %b %h want 11 0",
               nb_busy, nb_data);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (rd_busy_o !== 2'b00 || nb_busy !== 2'b00 ||
        busy_cnt_o !== 4'd0) begin
      n_fail++;
      $display("FAIL wb_next: got %b/%b cnt %0d want 00 0",
               rd_busy_o, nb_busy, busy_cnt_o);
    end
    n_checks++;
    if (nb_data[15:0] !== 16'h00AA) begin
      n_fail++;
      $display("FAIL wb_data: got %h want 00aa",
               nb_data[15:0]);
    end
  endtask

  task automatic test_issue_wb();
    @(negedge clk);
    issue_en = 1'b1;
    issue_addr_in = 3'd2;
    wr_en = 1'b1;
    wr_addr_in = 3'd2;
    wr_data_in = 16'h5A5A;
    rd_addr_in = {3'd2, 3'd0};
    #1;
    n_checks++;
    if (rd_busy_o[1] !== 1'b0 ||
        rd_data_o[31:16] !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL iwb_same: got %b %h want 0 5a5a",
               rd_busy_o[1], rd_data_o[31:16]);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (rd_busy_o[1] !== 1'b1 ||
        rd_data_o[31:16] !== 16'h5A5A ||
        busy_cnt_o !== 4'd1) begin
      n_fail++;
      $display("FAIL iwb_next: got %b %h %0d want 1 5a5a 1",
               rd_busy_o[1], rd_data_o[31:16],
               busy_cnt_o);
    end
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr_in = 3'd2;
    wr_data_in = 16'h1111;
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (busy_cnt_o !== 4'd0) begin
      n_fail++;
      $display("FAIL iwb_clear: got %0d want 0",
               busy_cnt_o);
    end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      @(negedge clk);
      issue_en = 1'b1;
      issue_addr_in = r[2:0];
    end
    @(negedge clk);
    idle();
    rd_addr_in = {3'd3, 3'd1};
    #1;
    n_checks++;
    if (busy_cnt_o !== 4'd3 || rd_busy_o !== 2'b11) begin
      n_fail++;
      $display("FAIL flush_pre: got %0d %b want 3 11",
               busy_cnt_o, rd_busy_o);
    end
    @(negedge clk);
    flush = 1'b1;
    issue_en = 1'b1;
    issue_addr_in = 3'd4;
    wr_en = 1'b1;
    wr_addr_in = 3'd6;
    wr_data_in = 16'h6666;
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (busy_cnt_o !== 4'd0) begin
      n_fail++;
      $display("FAIL flush_cnt: got %0d want 0",
               busy_cnt_o);
    end
    for (int a = 1; a <= 4; a++) begin
      rd_addr_in = {a[2:0], a[2:0]};
      #1;
      n_checks++;
      if (rd_busy_o !== 2'b00) begin
        n_fail++;
        $display("FAIL flush_busy a=%0d: got %b want 00",
                 a, rd_busy_o);
      end
    end
    rd_addr_in = {3'd6, 3'd3};
    #1;
    n_checks++;
    if (rd_data_o !== 32'h6666_BEEF) begin
      n_fail++;
      $display("FAIL flush_data: got %h want 6666beef",
               rd_data_o);
    end
    rd_addr_in = {3'd5, 3'd2};
    #1;
    n_checks++;
    if (rd_data_o !== 32'h00AA_1111) begin
      n_fail++;
      $display("FAIL flush_data2: got %h want 00aa1111",
               rd_data_o);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr_in = 3'd1;
    wr_data_in = 16'hA001;
    issue_en = 1'b1;
    issue_addr_in = 3'd7;
    @(negedge clk);
    issue_en = 1'b0;
    wr_addr_in = 3'd2;
    wr_data_in = 16'hA002;
    rd_addr_in = {3'd2, 3'd1};
    #1;
    n_checks++;
    if (rd_data_o !== 32'hA002_A001 ||
        busy_cnt_o !== 4'd1) begin
      n_fail++;
      $display("FAIL burst: got %h %0d want a002a001 1",
               rd_data_o, busy_cnt_o);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rd_data_o !== 32'h0 || nb_data !== 32'h0 ||
        busy_cnt_o !== 4'd0) begin
      n_fail++;
      $display("FAIL async_rst: got %h/%h %0d want 0 0",
               rd_data_o, nb_data, busy_cnt_o);
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
    rd_addr_in = {3'd7, 3'd1};
    #1;
    n_checks++;
    if (rd_data_o !== 32'h0 || rd_busy_o !== 2'b00) begin
      n_fail++;
      $display("FAIL post_rst: got %h %b want 0 00",
               rd_data_o, rd_busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_scoreboard();
    test_issue_wb();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with write-to-read bypass and a per-register pending-write scoreboard. It replaces the fixed 8x16, 2-read-port register file in the core's decode/writeback path. Decode marks a destination busy at issue. Writeback clears the busy bit and writes the data. Read ports return data plus a busy flag, so hazard logic can stall without a separate scoreboard.

## Interface
Parameters:
- XLEN, 16: register data width.
- NREG, 8: number of registers, power of two, at least 2. AW = $clog2(NREG) is derived.
- NRD, 2: number of read ports, 1 to 4.
- ZERO_REG, 1: when 1, register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1: when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: writeback strobe.
- wr_addr_in, input, AW: writeback register index.
- wr_data_in, input, XLEN: writeback data.
- issue_en, input, 1: marks a register as having a pending write.
- issue_addr_in, input, AW: register to mark busy.
- flush, input, 1: clears all busy bits; register contents are unchanged.
- rd_addr_in, input, NRD*AW: read addresses; port i occupies bits [i*AW +: AW].
- rd_data_o, output, NRD*XLEN: read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy_o, output, NRD: busy flag per read port.
- busy_cnt_o, output, AW+1: number of busy registers, registered.

## Operation
- Storage is NREG x XLEN flops.
- **Writable write.** A write is writable when wr_en=1 and not (ZERO_REG=1 and wr_addr_in=0).
  - It updates reg[wr_addr_in] at the next posedge.
  - It also clears busy[wr_addr_in].
- **Reads** are combinational, one mux per port.
  - If ZERO_REG=1 and the address is 0, rd_data_o is 0.
  - Else, if BYPASS=1 and a writable write targets the same address this cycle, rd_data_o is wr_data_in.
  - Otherwise rd_data_o is the stored register value.
- **Busy bit update** per register r, in priority order:
  1. flush=1: busy[r] is cleared. Issue and the writeback clear are ignored this cycle; the data write still happens.
  2. issue_en=1 and issue_addr_in=r (and r writable): busy[r] is set. Set wins over a same-cycle writeback clear, because the new producer supersedes the old one.
  3. Writable write to r: busy[r] is cleared.
  4. Otherwise busy[r] holds.
- **rd_busy_o[i]** = busy[rd_addr[i]], with two exceptions where it is 0:
  - ZERO_REG=1 and the address is 0.
  - BYPASS=1 and a writable write to that address occurs this cycle. The data is already valid on the bypass path, even if a same-cycle issue re-sets the bit for the next cycle.
- With BYPASS=0, a read of a register being written this cycle returns the old value and rd_busy_o reflects the stored busy bit.
- **busy_cnt_o** is a registered popcount of the next-state busy vector. It always equals the popcount of the stored busy bits and never exceeds NREG - ZERO_REG.
- Out-of-range addresses cannot occur because NREG is a power of two.

## Timing
- Reset (async assert, release synchronous to clk): all registers = 0, all busy = 0, busy_cnt_o = 0.
  - rd_data_o = 0 and rd_busy_o = 0 while rst is high.
- Read latency: 0 cycles, combinational from rd_addr_in, wr_*, and state.
- Write latency:
  - A write at edge N is visible from the stored value in cycle N+1.
  - It is visible in cycle N itself only with BYPASS=1.
- Issue latency: busy is visible on rd_busy_o the cycle after issue_en.
- Writeback and issue have no handshake; they are single-cycle strobes that are acted on whenever high.
- Reset asserted mid-operation: all state clears immediately. Any write or issue in that cycle is lost.
- All NRD ports may read the same address simultaneously; each returns identical data and busy.

## Test plan
- **Reset:** assert rst, read all addresses on all ports -> data 0, busy 0, busy_cnt_o 0.
- **Write/read with bypass:** write reg3=0xBEEF.
  - Same cycle with BYPASS=1: port0 reading 3 returns 0xBEEF.
  - Next cycle, with BYPASS=0 and BYPASS=1: returns 0xBEEF.
  - Write reg0=0x1234 with ZERO_REG=1: reg0 reads 0 forever.
- **Scoreboard:**
  - Issue reg5 -> next cycle rd_busy_o=1 and busy_cnt_o=1.
  - Writeback reg5=0x00AA -> same cycle busy=0 with BYPASS=1; next cycle busy=0 and count=0.
- **Simultaneous issue and writeback to reg2:** next cycle busy[2]=1, data=new wr_data, busy_cnt_o=1.
- **Flush:**
  - Issue regs 1, 2, 3 (count=3), then flush together with issue of reg4 -> count=0 and all busy=0.
  - Register data is unchanged.
- **Async reset mid-burst:** assert rst between clock edges during back-to-back writes -> outputs 0 immediately, without waiting for a clk edge.
